// File: rtl/lcd_frame_arbiter.sv
// lcd_frame_arbiter: frame-synchronous owner selection for a shared LCD pixel path
//   Inputs : lcd_pclk (clock), rst_n (async active-low reset), lcd_vs (vsync, active low),
//            data_req (driver pixel request), src_req[NSRC], src_data[NSRC*DW]
//   Outputs: src_gnt (one-hot/zero owner), src_rd_en (data_req steered to the owner),
//            src_frame_start (owner pulse per frame boundary), pixel_data (owner pixel or
//            BG_COLOR), frame_cnt (frames under the current grant, saturating)
module lcd_frame_arbiter #(
  parameter int              NSRC       = 4,
  parameter int              DW         = 24,
  parameter int              MIN_FRAMES = 8,
  parameter logic [DW-1:0]   BG_COLOR   = '0
) (
  input  logic                 lcd_pclk,
  input  logic                 rst_n,
  input  logic                 lcd_vs,
  input  logic                 data_req,
  input  logic [NSRC-1:0]      src_req,
  input  logic [NSRC*DW-1:0]   src_data,
  output logic [NSRC-1:0]      src_gnt,
  output logic [NSRC-1:0]      src_rd_en,
  output logic [NSRC-1:0]      src_frame_start,
  output logic [DW-1:0]        pixel_data,
  output logic [7:0]           frame_cnt
);
  localparam int IW = $clog2(NSRC);
  typedef enum logic {S_IDLE, S_OWN} state_t;
  state_t            r_state, w_nstate;
  logic [IW-1:0]     r_cur, w_ncur, w_low, w_rr;
  logic [7:0]        r_cnt, w_ncnt, w_cnt_inc;
  logic [NSRC-1:0]   r_fs, w_nfs;
  logic              r_vs_d, w_fb, w_low_ok, w_rr_ok, w_dwell;
  assign w_fb      = r_vs_d & ~lcd_vs;
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_dwell   = ({1'b0, r_cnt} + 9'd1) >= 9'(MIN_FRAMES);
  // Lowest-index requester, and first requester strictly after the owner (wrapping).
  // Descending loops let the closest candidate overwrite the farther ones.
  always_comb begin
    w_low    = '0;
    w_low_ok = 1'b0;
    w_rr     = '0;
    w_rr_ok  = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (src_req[i]) begin
        w_low    = IW'(i);
        w_low_ok = 1'b1;
      end
    for (int k = NSRC - 1; k >= 1; k--)
      if (src_req[(int'(r_cur) + k) % NSRC]) begin
        w_rr    = IW'((int'(r_cur) + k) % NSRC);
        w_rr_ok = 1'b1;
      end
  end
  always_ff @(posedge lcd_pclk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_cnt   <= '0;
      r_fs    <= '0;
      r_vs_d  <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_cur   <= w_ncur;
      r_cnt   <= w_ncnt;
      r_fs    <= w_nfs;
      r_vs_d  <= lcd_vs;
    end
  // Decisions happen only on the vsync falling edge; otherwise everything holds.
  always_comb begin
    w_nstate = r_state;
    w_ncur   = r_cur;
    w_ncnt   = r_cnt;
    w_nfs    = '0;
    if (w_fb) begin
      if (r_state == S_IDLE) begin
        if (w_low_ok) begin
          w_nstate = S_OWN;
          w_ncur   = w_low;
          w_ncnt   = '0;
        end
      end else if (!src_req[r_cur] || (w_dwell && w_rr_ok)) begin
        w_nstate = w_rr_ok ? S_OWN : S_IDLE;
        w_ncur   = w_rr_ok ? w_rr : r_cur;
        w_ncnt   = '0;
      end else
        w_ncnt = w_cnt_inc;
      w_nfs = (w_nstate == S_OWN) ? NSRC'(1) << w_ncur : '0;
    end
  end
  always_comb begin
    src_gnt         = (r_state == S_OWN) ? NSRC'(1) << r_cur : '0;
    src_rd_en       = {NSRC{data_req}} & src_gnt;
    src_frame_start = r_fs;
    frame_cnt       = r_cnt;
    pixel_data      = (r_state == S_OWN) ? src_data[int'(r_cur) * DW +: DW] : BG_COLOR;
  end
endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// tb_lcd_frame_arbiter: randomized bench against a frame-level reference model
module tb_lcd_frame_arbiter;
  localparam int NSRC = 4;
  localparam int DW   = 24;
  localparam int MINF = 8;
  localparam logic [DW-1:0] BG = 24'h0A0B0C;
  logic                 lcd_pclk = 1'b0;
  logic                 rst_n    = 1'b1;
  logic                 lcd_vs   = 1'b1;
  logic                 data_req = 1'b0;
  logic [NSRC-1:0]      src_req  = '0;
  logic [NSRC*DW-1:0]   src_data = '0;
  logic [NSRC-1:0]      src_gnt, src_rd_en, src_frame_start;
  logic [DW-1:0]        pixel_data;
  logic [7:0]           frame_cnt;
  lcd_frame_arbiter #(.NSRC(NSRC), .DW(DW), .MIN_FRAMES(MINF), .BG_COLOR(BG)) dut (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .lcd_vs(lcd_vs), .data_req(data_req),
    .src_req(src_req), .src_data(src_data), .src_gnt(src_gnt), .src_rd_en(src_rd_en),
    .src_frame_start(src_frame_start), .pixel_data(pixel_data), .frame_cnt(frame_cnt)
  );
  always #5 lcd_pclk = ~lcd_pclk;
  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  bit rnd_req = 1'b0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  // Reference model: owner index (-1 = none), dwell count, frame-start pulse.
  int              m_own = -1;
  int              m_cnt = 0;
  int              m_nxt;
  logic [NSRC-1:0] m_fs  = '0;
  logic            m_vs  = 1'b1;
  function automatic int find(int start, int n, logic [NSRC-1:0] r);
    for (int k = 0; k < n; k++)
      if (r[(start + k) % NSRC]) return (start + k) % NSRC;
    return -1;
  endfunction
  always @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1;
      m_cnt = 0;
      m_fs  = '0;
      m_vs  = 1'b1;
    end else begin
      m_fs = '0;
      if (m_vs && !lcd_vs) begin
        if (m_own < 0) begin
          m_own = find(0, NSRC, src_req);
          m_cnt = 0;
        end else if (!src_req[m_own]) begin
          m_own = find(m_own + 1, NSRC - 1, src_req);
          m_cnt = 0;
        end else begin
          m_nxt = find(m_own + 1, NSRC - 1, src_req);
          if (m_cnt + 1 >= MINF && m_nxt >= 0) begin
            m_own = m_nxt;
            m_cnt = 0;
          end else
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        if (m_own >= 0) m_fs[m_own] = 1'b1;
      end
      m_vs = lcd_vs;
    end
  end
  logic [NSRC-1:0] e_gnt;
  logic [DW-1:0]   e_pix;
  always @(negedge lcd_pclk) if (mon_en) begin
    e_gnt = (m_own < 0) ? '0 : NSRC'(1) << m_own;
    e_pix = BG;
    if (m_own >= 0) e_pix = src_data[m_own*DW +: DW];
    check("gnt", src_gnt, e_gnt);
    check("rd_en", src_rd_en, data_req ? e_gnt : '0);
    check("frame_start", src_frame_start, m_fs);
    check("frame_cnt", frame_cnt, m_cnt);
    check("pixel", pixel_data, e_pix);
    check("onehot0", $onehot0(src_gnt), 1);
  end
  task automatic tick();
    @(posedge lcd_pclk);
    #1;
    data_req = 1'($urandom);
    src_data = {$urandom, $urandom, $urandom};
    if (rnd_req && $urandom_range(0, 7) == 0) src_req = NSRC'($urandom);
  endtask
  task automatic frame(int act);
    lcd_vs = 1'b0;
    tick();
    lcd_vs = 1'b1;
    repeat (act) tick();
  endtask
  task automatic settle();
    @(negedge lcd_pclk);
    #1;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge lcd_pclk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    settle();
    check("rst_gnt", src_gnt, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_pix", pixel_data, BG);
    repeat (3) frame(16);
    settle();
    check("t1_gnt", src_gnt, 0);
    check("t1_pix", pixel_data, BG);
    src_req = 4'b0110;
    frame(16);
    settle();
    check("t2_gnt", src_gnt, 4'b0010);
    check("t2_pix", pixel_data, src_data[DW +: DW]);
    src_req = 4'b1010;
    repeat (7) frame(16);
    settle();
    check("t3_hold_gnt", src_gnt, 4'b0010);
    check("t3_hold_cnt", frame_cnt, 7);
    frame(16);
    settle();
    check("t3_rot_gnt", src_gnt, 4'b1000);
    check("t3_rot_cnt", frame_cnt, 0);
    repeat (8) frame(16);
    settle();
    check("t3_wrap_gnt", src_gnt, 4'b0010);
    src_req = 4'b1000;
    frame(16);
    repeat (2) frame(16);
    settle();
    check("t4_gnt", src_gnt, 4'b1000);
    check("t4_cnt", frame_cnt, 2);
    src_req = 4'b0001;
    data_req = 1'b1;
    settle();
    check("t4_rd_en_mid", src_rd_en, 4'b1000);
    repeat (5) tick();
    frame(16);
    settle();
    check("t4_release_gnt", src_gnt, 4'b0001);
    src_req = '0;
    frame(16);
    settle();
    check("t5_gnt", src_gnt, 0);
    check("t5_pix", pixel_data, BG);
    src_req = 4'b0100;
    frame(16);
    settle();
    check("t6_gnt", src_gnt, 4'b0100);
    repeat (3) tick();
    data_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", src_gnt, 0);
    check("t6_rst_rd_en", src_rd_en, 0);
    check("t6_rst_pix", pixel_data, BG);
    check("t6_rst_cnt", frame_cnt, 0);
    repeat (2) @(posedge lcd_pclk);
    #3 rst_n = 1'b1;
    repeat (6) tick();
    settle();
    check("t6_no_grant", src_gnt, 0);
    frame(16);
    settle();
    check("t6_regrant", src_gnt, 4'b0100);
    repeat (257) frame(2);
    settle();
    check("sat_cnt", frame_cnt, 255);
    check("sat_gnt", src_gnt, 4'b0100);
    rnd_req = 1'b1;
    repeat (40) frame($urandom_range(4, 20));
    settle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
